// File: rtl/hs_pkg.sv
// hs_pkg: shared types and default widths for the handshake slave receiver
package hs_pkg;
  typedef enum logic {IDLE, TRACK} chk_state_t;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
endpackage

// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: small synchronous FIFO, flop storage, head word read directly from the register array
module hs_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  // storage, pointers and occupancy; storage zeroed on reset so the head reads 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/hs_slave_rx.sv
// hs_slave_rx: valid/ready stream sink that buffers words, re-emits them, and checks the +1 sequence
module hs_slave_rx
  import hs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              S_valid,
  input  logic [DATA_W-1:0] S_data,
  output logic              S_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clr,
  output logic [CNT_W-1:0]  rx_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic              locked
);
  chk_state_t state, state_n;
  logic [DATA_W-1:0] expected, expected_n;
  logic [CNT_W-1:0] rx_n, err_n;
  logic flag_n, full, empty, push, pop;
  assign S_ready   = !full;
  assign out_valid = !empty;
  assign push      = S_valid && S_ready;
  assign pop       = out_valid && out_ready;
  assign locked    = state == TRACK;
  hs_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (S_data),
    .pop  (pop),
    .full (full),
    .empty(empty),
    .head (out_data)
  );
  // checker and statistics registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      expected <= '0;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      state    <= state_n;
      expected <= expected_n;
      rx_cnt   <= rx_n;
      err_cnt  <= err_n;
      err_flag <= flag_n;
    end
  // next checker state: lock on first word, resync to the received word on mismatch, saturate counters
  always_comb begin
    state_n    = state;
    expected_n = expected;
    rx_n       = rx_cnt;
    err_n      = err_cnt;
    flag_n     = err_flag;
    if (clr) begin
      state_n = IDLE;
      rx_n    = '0;
      err_n   = '0;
      flag_n  = 1'b0;
    end else if (push) begin
      state_n    = TRACK;
      expected_n = S_data + DATA_W'(1);
      rx_n       = rx_cnt + CNT_W'(rx_cnt != '1);
      if (state == TRACK && S_data != expected) begin
        err_n  = err_cnt + CNT_W'(err_cnt != '1);
        flag_n = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hs_slave_rx.sv
// tb_hs_slave_rx: randomized and directed checks of hs_slave_rx against a queue-based reference model
module tb_hs_slave_rx;
  logic clk = 0, rst = 1, S_valid = 0, out_ready = 0, clr = 0;
  logic [7:0] S_data = 0;
  logic S_ready, out_valid, err_flag, locked;
  logic [7:0] out_data;
  logic [15:0] rx_cnt, err_cnt;
  int vec = 0, mis = 0;
  int mq[$], q_in[$], q_out[$];
  int m_rx, m_err, m_prev;
  bit m_flag, m_locked;

  hs_slave_rx dut (
    .clk(clk), .rst(rst), .S_valid(S_valid), .S_data(S_data), .S_ready(S_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .clr(clr),
    .rx_cnt(rx_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete(); q_in.delete(); q_out.delete();
    m_rx = 0; m_err = 0; m_prev = 0; m_flag = 0; m_locked = 0;
  endtask

  task automatic cycle(input bit v, input int d, input bit r, input bit c);
    bit acc, pp;
    S_valid = v; S_data = 8'(d); out_ready = r; clr = c;
    acc = v && mq.size() < 4;
    pp  = r && mq.size() > 0;
    @(posedge clk); #1;
    if (pp) q_out.push_back(mq.pop_front());
    if (acc) begin mq.push_back(d % 256); q_in.push_back(d % 256); end
    if (c) begin
      m_rx = 0; m_err = 0; m_flag = 0; m_locked = 0;
    end else if (acc) begin
      m_rx = m_rx < 65535 ? m_rx + 1 : m_rx;
      if (m_locked && d % 256 != (m_prev + 1) % 256) begin
        m_err = m_err < 65535 ? m_err + 1 : m_err;
        m_flag = 1;
      end
      m_prev = d % 256; m_locked = 1;
    end
    S_valid = 0; clr = 0;
  endtask

  task automatic pulse_rst();
    rst = 1; S_valid = 0; out_ready = 0; clr = 0;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    vec++; if (out_valid !== 0 || out_data !== 0) begin mis++; $display("FAIL reset_out: valid=%0b data=%0d want 0/0", out_valid, out_data); end
    vec++; if (rx_cnt !== 0 || err_cnt !== 0 || err_flag !== 0 || locked !== 0) begin mis++; $display("FAIL reset_stats: rx=%0d err=%0d flag=%0b lock=%0b want 0", rx_cnt, err_cnt, err_flag, locked); end
    @(posedge clk); #1; rst = 0; model_reset();
    vec++; if (S_ready !== 1) begin mis++; $display("FAIL reset_ready: got %0b want 1", S_ready); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      cycle(1, i, 1, 0);
      vec++; if (out_valid !== 1 || out_data !== 8'(i)) begin mis++; $display("FAIL stream_out[%0d]: valid=%0b data=%0d want 1/%0d", i, out_valid, out_data, i); end
    end
    cycle(0, 0, 1, 0);
    vec++; if (rx_cnt !== 10 || err_cnt !== 0 || locked !== 1 || out_valid !== 0) begin mis++; $display("FAIL stream_stats: rx=%0d err=%0d lock=%0b ov=%0b want 10/0/1/0", rx_cnt, err_cnt, locked, out_valid); end
  endtask

  task automatic test_backpressure();
    pulse_rst();
    for (int i = 0; i < 6; i++) begin
      vec++; if (S_ready !== (i < 4)) begin mis++; $display("FAIL bp_ready[%0d]: got %0b want %0b", i, S_ready, i < 4); end
      cycle(1, i, 0, 0);
    end
    vec++; if (rx_cnt !== 4 || m_rx != 4) begin mis++; $display("FAIL bp_accepted: rx=%0d model=%0d want 4", rx_cnt, m_rx); end
    for (int k = 0; k < 4; k++) begin
      vec++; if (S_ready !== (k != 0) || out_valid !== 1 || out_data !== 8'(k)) begin mis++; $display("FAIL bp_drain[%0d]: ready=%0b valid=%0b data=%0d want %0b/1/%0d", k, S_ready, out_valid, out_data, k != 0, k); end
      cycle(0, 0, 1, 0);
    end
    vec++; if (out_valid !== 0) begin mis++; $display("FAIL bp_empty: valid=%0b want 0", out_valid); end
  endtask

  task automatic test_wrap();
    int a[4] = '{254, 255, 0, 1};
    int b[4] = '{5, 6, 9, 10};
    pulse_rst();
    foreach (a[i]) cycle(1, a[i], 1, 0);
    vec++; if (err_cnt !== 0 || err_flag !== 0 || locked !== 1) begin mis++; $display("FAIL wrap_legal: err=%0d flag=%0b lock=%0b want 0/0/1", err_cnt, err_flag, locked); end
    cycle(0, 0, 1, 1);
    foreach (b[i]) cycle(1, b[i], 1, 0);
    vec++; if (err_cnt !== 1 || err_flag !== 1 || err_cnt !== 16'(m_err)) begin mis++; $display("FAIL wrap_resync: err=%0d flag=%0b want 1/1", err_cnt, err_flag); end
    vec++; if (rx_cnt !== 4) begin mis++; $display("FAIL wrap_rx: rx=%0d want 4", rx_cnt); end
  endtask

  task automatic test_random();
    int cnt = $urandom_range(0, 255);
    pulse_rst();
    for (int i = 0; i < 600; i++) begin
      bit v = i % 2 == 0;
      bit acc = v && mq.size() < 4;
      vec++; if (S_ready !== (mq.size() < 4)) begin mis++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, S_ready, mq.size() < 4); end
      cycle(v, cnt, 1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0);
      if (acc) cnt = $urandom_range(0, 15) == 0 ? $urandom_range(0, 255) : (cnt + 1) % 256;
      vec++; if (out_valid !== (mq.size() > 0) || (mq.size() > 0 && out_data !== 8'(mq[0]))) begin mis++; $display("FAIL rnd_out[%0d]: valid=%0b data=%0d want %0b/%0d", i, out_valid, out_data, mq.size() > 0, mq.size() > 0 ? mq[0] : 0); end
      vec++; if (rx_cnt !== 16'(m_rx) || err_cnt !== 16'(m_err) || err_flag !== m_flag || locked !== m_locked) begin mis++; $display("FAIL rnd_stats[%0d]: rx=%0d err=%0d flag=%0b lock=%0b want %0d/%0d/%0b/%0b", i, rx_cnt, err_cnt, err_flag, locked, m_rx, m_err, m_flag, m_locked); end
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    vec++; if (q_in.size() != q_out.size() || q_in != q_out || out_valid !== 0) begin mis++; $display("FAIL rnd_sequence: in=%0d out=%0d words, valid=%0b want equal/0", q_in.size(), q_out.size(), out_valid); end
  endtask

  task automatic test_clr();
    int want[4] = '{10, 11, 50, 77};
    pulse_rst();
    cycle(1, 10, 0, 0);
    cycle(1, 11, 0, 0);
    cycle(0, 0, 0, 1);
    vec++; if (rx_cnt !== 0 || locked !== 0 || out_valid !== 1 || out_data !== 10) begin mis++; $display("FAIL clr_keep: rx=%0d lock=%0b valid=%0b data=%0d want 0/0/1/10", rx_cnt, locked, out_valid, out_data); end
    cycle(1, 50, 0, 1);
    vec++; if (rx_cnt !== 0 || locked !== 0) begin mis++; $display("FAIL clr_accept: rx=%0d lock=%0b want 0/0", rx_cnt, locked); end
    cycle(1, 77, 0, 0);
    vec++; if (rx_cnt !== 1 || err_cnt !== 0 || locked !== 1) begin mis++; $display("FAIL clr_relock: rx=%0d err=%0d lock=%0b want 1/0/1", rx_cnt, err_cnt, locked); end
    foreach (want[k]) begin
      vec++; if (out_valid !== 1 || out_data !== 8'(want[k])) begin mis++; $display("FAIL clr_drain[%0d]: valid=%0b data=%0d want 1/%0d", k, out_valid, out_data, want[k]); end
      cycle(0, 0, 1, 0);
    end
  endtask

  task automatic test_rst_mid();
    int w[4] = '{1, 2, 3, 9};
    pulse_rst();
    foreach (w[i]) cycle(1, w[i], 0, 0);
    vec++; if (err_flag !== 1 || S_ready !== 0 || out_valid !== 1) begin mis++; $display("FAIL mid_pre: flag=%0b ready=%0b valid=%0b want 1/0/1", err_flag, S_ready, out_valid); end
    #2 rst = 1;
    #1;
    vec++; if (out_valid !== 0 || out_data !== 0 || rx_cnt !== 0 || err_cnt !== 0 || err_flag !== 0 || locked !== 0) begin mis++; $display("FAIL mid_async: valid=%0b data=%0d rx=%0d err=%0d flag=%0b lock=%0b want all 0", out_valid, out_data, rx_cnt, err_cnt, err_flag, locked); end
    @(posedge clk); #1; rst = 0; model_reset();
    vec++; if (S_ready !== 1) begin mis++; $display("FAIL mid_ready: got %0b want 1", S_ready); end
    cycle(1, 42, 1, 0);
    vec++; if (out_valid !== 1 || out_data !== 42 || rx_cnt !== 1) begin mis++; $display("FAIL mid_resume: valid=%0b data=%0d rx=%0d want 1/42/1", out_valid, out_data, rx_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_random();
    test_clr();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
